writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-side front end for the 16x16 register file and its Z/O/N flag register. Accepts results from the ALU and memory stages over valid/ready handshakes and buffers them in a small in-order queue. Retires one entry per cycle onto the register file's single write port and flag enables. Exposes a two-port lookup so decode can bypass values still waiting in the queue.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  ALU result offered
- a_ready  out  1  ALU result accepted this cycle when high with a_valid
- a_dst  in  4  ALU destination register
- a_wr  in  1  ALU result writes a register
- a_data  in  16  ALU result
- a_z, a_o, a_n  in  1 each  ALU flag values
- a_z_en, a_o_en, a_n_en  in  1 each  ALU flag update enables
- m_valid  in  1  load result offered
- m_ready  out  1  load result accepted this cycle when high with m_valid
- m_dst  in  4  load destination register
- m_data  in  16  load data
- WriteReg  out  1  register-file write enable
- DstReg  out  4  register-file write address
- DstData  out  16  register-file write data
- Z_in, O_in, N_in  out  1 each  flag values to flag register
- Z_en, O_en, N_en  out  1 each  flag write enables
- q1_reg, q2_reg  in  4 each  lookup register ids
- q1_hit, q2_hit  out  1 each  queue holds a pending write to that register
- q1_data, q2_data  out  16 each  data of youngest matching entry
- empty, full  out  1 each  queue status
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry: {wr, dst, data, z, o, n, z_en, o_en, n_en}; load entries have wr=1 and all flag enables 0.
- Retire: when count>0, head entry drives WriteReg=wr & (dst!=0), DstReg, DstData, flag values and enables; head pops at next edge. The register file always accepts, so no stall.
- When empty, WriteReg=0 and all *_en=0. DstReg, DstData and flag values are 0.
- Free slots this cycle: free = DEPTH - count + (count!=0), counting the pop.
- Accept rules:
  - free>=2: both ready.
  - free==1: m_ready=1 and a_ready=!m_valid.
  - free==0: neither ready.
- Enqueue order when both are accepted in one cycle: memory entry first (older instruction), ALU entry second.
- Null writes: an ALU offer with (a_wr=0 or a_dst=0) and all flag enables 0, or a load with m_dst=0, is acknowledged under the same ready rules but not enqueued.
- R0 writes that carry flag enables are enqueued; they retire with WriteReg=0 and their flag enables asserted.
- Lookup: qN_hit=1 if any valid entry has wr=1, dst==qN_reg and dst!=0. qN_data is the data of the youngest such entry. Otherwise hit=0 and data=0.
- Lookup is combinational from queue state only. Same-cycle offers are not visible to it. The head entry being retired this cycle is visible.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

## Timing
- Accept at edge N: entry is visible on outputs and lookup after edge N, is written into the register file at edge N+1, and the queue frees it at edge N+1.
- Minimum accept-to-register-file latency is 1 cycle; throughput is 1 retire per cycle.
- Simultaneous enqueue and pop is legal. count(N+1) = count(N) + accepted(N) - (count(N)!=0).
- Reset, asynchronous:
  - Pointers and count are 0, so empty=1, full=0.
  - WriteReg=0, all *_en=0, DstReg=0, DstData=0.
  - q*_hit=0.
  - a_ready=m_ready=1 while rst is low and the queue is empty.
  - Reset mid-operation discards all queued entries; no partial write is issued.
- Ready depends only on registered state and m_valid; there is no combinational path from a_valid to any ready.

## Structure
- wb_pkg: wb_entry_t packed struct, REG_ZERO=4'd0, DEPTH default, count width function.
- Sub-module wb_entry_fifo holds the storage array, head/tail pointers, count, 0/1/2-push with 1-pop, and a per-entry match vector.
- writeback_queue holds the handshake, null-write filter, ordering, youngest-match selection and output drive.

## Test plan
- Single ALU write r3=0x1234 with z_en=1, z=1 into an empty queue: next cycle WriteReg=1, DstReg=3, DstData=0x1234, Z_en=1, Z_in=1; empty=1 after the following edge.
- Both ports valid in one cycle (m: r5=0xAAAA, a: r5=0x5555) with count=0: both accepted; q1_reg=5 gives hit=1, data=0x5555; retire order is 0xAAAA then 0x5555.
- Fill to DEPTH=4 with retire stalled by back-to-back offers: check free==1 gives m_ready=1 and a_ready=0 when both valid; full=1 when count=4; verify wrap over 10 entries stays in order.
- ALU r0 with data 0xFFFF and n_en=1, n=1: retires with WriteReg=0, N_en=1. A load to r0 is acknowledged and count is unchanged.
- Lookup misses: q1_reg=0 gives hit=0 even with an r0 flag entry queued; a same-cycle offer to r7 gives q2_reg=7 hit=0 until the next cycle.
- Assert rst with 3 entries queued: outputs go to reset values immediately without a clock; after release, no stale writes are issued.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// An entry is one pending register-file/flag update in retire order.
package wb_pkg;

    localparam int DEPTH_DEFAULT = 4;
    localparam logic [3:0] REG_ZERO = 4'd0;

    typedef struct packed {
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        z;
        logic        o;
        logic        n;
        logic        z_en;
        logic        o_en;
        logic        n_en;
    } wb_entry_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order entry storage: up to two pushes and one pop per cycle.
// Entries are also presented oldest-first with a per-entry lookup match.
module wb_entry_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW = count_width(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              push_n_i,
    input  wb_entry_t               push0_i,
    input  wb_entry_t               push1_i,
    input  logic                    pop_i,
    input  logic [3:0]              q1_reg_i,
    input  logic [3:0]              q2_reg_i,
    output wb_entry_t               head_o,
    output logic [CW-1:0]           count_o,
    output wb_entry_t [DEPTH-1:0]   age_entry_o,
    output logic [DEPTH-1:0]        match1_o,
    output logic [DEPTH-1:0]        match2_o
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [PW-1:0]         tail_p1;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        tail_p1 = tail_q + PW'(1);
        if (push_n_i != 2'd0) begin
            mem_d[tail_q] = push0_i;
        end
        if (push_n_i == 2'd2) begin
            mem_d[tail_p1] = push1_i;
        end
        head_d  = pop_i ? head_q + PW'(1) : head_q;
        tail_d  = tail_q + PW'(push_n_i);
        count_d = count_q + CW'(push_n_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Index i of the age view is the i-th oldest entry; only the first count_q are live.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry_o[i] = mem_q[head_q + PW'(i)];
            match1_o[i] = (CW'(i) < count_q) && age_entry_o[i].wr &&
                          (age_entry_o[i].dst == q1_reg_i) && (q1_reg_i != REG_ZERO);
            match2_o[i] = (CW'(i) < count_q) && age_entry_o[i].wr &&
                          (age_entry_o[i].dst == q2_reg_i) && (q2_reg_i != REG_ZERO);
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Write-side front end for the register file and Z/O/N flags: handshakes,
// null-write filtering, load-before-ALU ordering, retire drive and bypass lookup.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [3:0]    a_dst,
    input  logic          a_wr,
    input  logic [15:0]   a_data,
    input  logic          a_z,
    input  logic          a_o,
    input  logic          a_n,
    input  logic          a_z_en,
    input  logic          a_o_en,
    input  logic          a_n_en,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [3:0]    m_dst,
    input  logic [15:0]   m_data,
    output logic          WriteReg,
    output logic [3:0]    DstReg,
    output logic [15:0]   DstData,
    output logic          Z_in,
    output logic          O_in,
    output logic          N_in,
    output logic          Z_en,
    output logic          O_en,
    output logic          N_en,
    input  logic [3:0]    q1_reg,
    input  logic [3:0]    q2_reg,
    output logic          q1_hit,
    output logic          q2_hit,
    output logic [15:0]   q1_data,
    output logic [15:0]   q2_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    wb_entry_t             head, m_ent, a_ent, push0, push1;
    wb_entry_t [DEPTH-1:0] age_entry;
    logic [DEPTH-1:0]      match1, match2;
    logic [CW-1:0]         cnt;
    logic [1:0]            push_n;
    logic                  nonempty, m_enq, a_enq;
    int                    free_slots;

    assign nonempty = (cnt != '0);

    // Free slots already include the head that retires this cycle.
    always_comb begin
        free_slots = DEPTH - int'(cnt) + (nonempty ? 1 : 0);
        m_ready    = (free_slots >= 1);
        a_ready    = (free_slots >= 2) || ((free_slots == 1) && !m_valid);
    end

    always_comb begin
        m_ent      = '0;
        m_ent.wr   = 1'b1;
        m_ent.dst  = m_dst;
        m_ent.data = m_data;

        a_ent      = '0;
        a_ent.wr   = a_wr;
        a_ent.dst  = a_dst;
        a_ent.data = a_data;
        a_ent.z    = a_z;
        a_ent.o    = a_o;
        a_ent.n    = a_n;
        a_ent.z_en = a_z_en;
        a_ent.o_en = a_o_en;
        a_ent.n_en = a_n_en;

        m_enq  = m_valid && m_ready && (m_dst != REG_ZERO);
        a_enq  = a_valid && a_ready &&
                 ((a_wr && (a_dst != REG_ZERO)) || a_z_en || a_o_en || a_n_en);
        push_n = {1'b0, m_enq} + {1'b0, a_enq};
        push0  = m_enq ? m_ent : a_ent;
        push1  = a_ent;
    end

    wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_n_i   (push_n),
        .push0_i    (push0),
        .push1_i    (push1),
        .pop_i      (nonempty),
        .q1_reg_i   (q1_reg),
        .q2_reg_i   (q2_reg),
        .head_o     (head),
        .count_o    (cnt),
        .age_entry_o(age_entry),
        .match1_o   (match1),
        .match2_o   (match2)
    );

    always_comb begin
        WriteReg = 1'b0;
        DstReg   = '0;
        DstData  = '0;
        Z_in     = 1'b0;
        O_in     = 1'b0;
        N_in     = 1'b0;
        Z_en     = 1'b0;
        O_en     = 1'b0;
        N_en     = 1'b0;
        if (nonempty) begin
            WriteReg = head.wr && (head.dst != REG_ZERO);
            DstReg   = head.dst;
            DstData  = head.data;
            Z_in     = head.z;
            O_in     = head.o;
            N_in     = head.n;
            Z_en     = head.z_en;
            O_en     = head.o_en;
            N_en     = head.n_en;
        end
    end

    // Scanning oldest to youngest leaves the youngest match selected.
    always_comb begin
        q1_hit  = 1'b0;
        q1_data = '0;
        q2_hit  = 1'b0;
        q2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match1[i]) begin
                q1_hit  = 1'b1;
                q1_data = age_entry[i].data;
            end
            if (match2[i]) begin
                q2_hit  = 1'b1;
                q2_data = age_entry[i].data;
            end
        end
    end

    assign empty = !nonempty;
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_valid, a_wr, a_z, a_o, a_n, a_z_en, a_o_en, a_n_en;
    logic [3:0] a_dst, m_dst, q1_reg, q2_reg;
    logic [15:0] a_data, m_data;
    logic m_valid;
    logic a_ready, m_ready;
    logic WriteReg, Z_in, O_in, N_in, Z_en, O_en, N_en;
    logic [3:0] DstReg;
    logic [15:0] DstData, q1_data, q2_data;
    logic q1_hit, q2_hit, empty, full;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    typedef struct {
        bit        wr;
        bit [3:0]  dst;
        bit [15:0] data;
        bit [5:0]  fl;   // {z, o, n, z_en, o_en, n_en}
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_wr(a_wr), .a_data(a_data),
        .a_z(a_z), .a_o(a_o), .a_n(a_n), .a_z_en(a_z_en), .a_o_en(a_o_en), .a_n_en(a_n_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_dst(m_dst), .m_data(m_data),
        .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
        .Z_in(Z_in), .O_in(O_in), .N_in(N_in), .Z_en(Z_en), .O_en(O_en), .N_en(N_en),
        .q1_reg(q1_reg), .q2_reg(q2_reg), .q1_hit(q1_hit), .q2_hit(q2_hit),
        .q1_data(q1_data), .q2_data(q2_data),
        .empty(empty), .full(full), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int free_of(input int n);
        return DEPTH - n + ((n != 0) ? 1 : 0);
    endfunction

    function automatic void lookup(input bit [3:0] r, output bit hit, output bit [15:0] d);
        hit = 0;
        d   = '0;
        if (r != 0) begin
            foreach (mq[i]) begin
                if (mq[i].wr && mq[i].dst == r) begin
                    hit = 1;
                    d   = mq[i].data;
                end
            end
        end
    endfunction

    // Reference model: retire the oldest entry, then append accepted non-null offers, load first.
    always @(posedge clk) begin : model_upd
        int  n, fr;
        bit  mr, ar;
        ent_t e;
        if (!rst) begin
            n  = mq.size();
            fr = free_of(n);
            mr = (fr >= 1);
            ar = (fr >= 2) || (fr == 1 && !m_valid);
            if (n > 0) mq.delete(0);
            if (m_valid && mr && m_dst != 0) begin
                e = '{wr: 1'b1, dst: m_dst, data: m_data, fl: 6'b0};
                mq.push_back(e);
            end
            if (a_valid && ar && ((a_wr && a_dst != 0) || a_z_en || a_o_en || a_n_en)) begin
                e = '{wr: a_wr, dst: a_dst, data: a_data,
                      fl: {a_z, a_o, a_n, a_z_en, a_o_en, a_n_en}};
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        int n, fr;
        bit h1, h2;
        bit [15:0] d1, d2;
        logic [26:0] exp_ret;
        if (chk_en) begin
            n  = mq.size();
            fr = free_of(n);
            chk("m_ready", m_ready, fr >= 1);
            chk("a_ready", a_ready, (fr >= 2) || (fr == 1 && !m_valid));
            chk("count", count, n);
            chk("empty", empty, n == 0);
            chk("full", full, n == DEPTH);
            exp_ret = '0;
            if (n > 0) exp_ret = {mq[0].wr && mq[0].dst != 0, mq[0].dst, mq[0].data, mq[0].fl};
            chk("retire", {WriteReg, DstReg, DstData, Z_in, O_in, N_in, Z_en, O_en, N_en}, exp_ret);
            lookup(q1_reg, h1, d1);
            lookup(q2_reg, h2, d2);
            chk("lookup1", {q1_hit, q1_data}, {h1, d1});
            chk("lookup2", {q2_hit, q2_data}, {h2, d2});
        end
    end

    task automatic idle();
        a_valid = 0; a_wr = 0; a_dst = 0; a_data = 0;
        a_z = 0; a_o = 0; a_n = 0; a_z_en = 0; a_o_en = 0; a_n_en = 0;
        m_valid = 0; m_dst = 0; m_data = 0;
        q1_reg = 0; q2_reg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input bit [3:0] d, input bit [15:0] v, input bit wr, input bit [5:0] fl);
        a_valid = 1; a_dst = d; a_data = v; a_wr = wr;
        {a_z, a_o, a_n, a_z_en, a_o_en, a_n_en} = fl;
    endtask

    task automatic offer_m(input bit [3:0] d, input bit [15:0] v);
        m_valid = 1; m_dst = d; m_data = v;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_write", WriteReg, 0);
        chk("rst_ready", {a_ready, m_ready}, 2'b11);
        rst = 0;
        tick();

        // Single ALU write with Z flag.
        offer_a(4'd3, 16'h1234, 1'b1, 6'b100_100);
        tick();
        idle();
        #1;
        chk("t1_ret", {WriteReg, DstReg, DstData, Z_en, Z_in}, {1'b1, 4'd3, 16'h1234, 1'b1, 1'b1});
        tick();
        chk("t1_empty", empty, 1);

        // Both ports into the same register: load is older.
        offer_m(4'd5, 16'hAAAA);
        offer_a(4'd5, 16'h5555, 1'b1, 6'b0);
        @(negedge clk);
        chk("t2_ready", {a_ready, m_ready}, 2'b11);
        tick();
        idle();
        q1_reg = 4'd5;
        #1;
        chk("t2_hit", {q1_hit, q1_data}, {1'b1, 16'h5555});
        chk("t2_first", {count, DstData}, {CW'(2), 16'hAAAA});
        tick();
        chk("t2_second", DstData, 16'h5555);
        tick();
        chk("t2_empty", empty, 1);

        // Back-to-back dual offers fill the queue and wrap the pointers.
        for (int c = 0; c < 7; c++) begin
            offer_m(4'(c + 1), 16'h3000 + 16'(2 * c));
            offer_a(4'(c + 9), 16'h3001 + 16'(2 * c), 1'b1, 6'b0);
            @(negedge clk);
            if (c >= 3) begin
                chk("t3_full_ready", {full, m_ready, a_ready}, 3'b110);
            end
            tick();
        end
        idle();
        repeat (6) tick();
        chk("t3_drained", empty, 1);

        // R0 with a flag enable retires flags only; a load to r0 is dropped.
        offer_a(4'd0, 16'hFFFF, 1'b1, 6'b001_001);
        tick();
        idle();
        #1;
        chk("t4_r0", {WriteReg, N_en, N_in, DstData, q1_hit}, {1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0});
        tick();
        offer_m(4'd0, 16'hBEEF);
        @(negedge clk);
        chk("t4_m_ready", m_ready, 1);
        tick();
        idle();
        #1;
        chk("t4_count", count, 0);

        // Same-cycle offers are invisible to lookup.
        offer_a(4'd7, 16'h7777, 1'b1, 6'b0);
        q2_reg = 4'd7;
        #1;
        chk("t5_miss", q2_hit, 0);
        tick();
        idle();
        q2_reg = 4'd7;
        #1;
        chk("t5_hit", {q2_hit, q2_data}, {1'b1, 16'h7777});
        tick();

        // Asynchronous reset with three entries queued.
        offer_m(4'd1, 16'h1111);
        offer_a(4'd2, 16'h2222, 1'b1, 6'b0);
        tick();
        offer_m(4'd3, 16'h3333);
        offer_a(4'd4, 16'h4444, 1'b1, 6'b0);
        tick();
        idle();
        q1_reg = 4'd4;
        #1;
        chk("t6_count", count, 3);
        #1;
        rst = 1;
        mq.delete();
        #1;
        chk("t6_async", {WriteReg, count, empty, q1_hit, Z_en, O_en, N_en},
            {1'b0, CW'(0), 1'b1, 1'b0, 3'b000});
        @(negedge clk);
        rst = 0;
        repeat (3) tick();
        chk("t6_no_stale", {WriteReg, empty}, 2'b01);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_wr    = ($urandom_range(0, 4) != 0);
            a_dst   = 4'($urandom_range(0, 7));
            a_data  = 16'($urandom);
            {a_z, a_o, a_n} = 3'($urandom);
            a_z_en  = ($urandom_range(0, 3) == 0);
            a_o_en  = ($urandom_range(0, 5) == 0);
            a_n_en  = ($urandom_range(0, 5) == 0);
            m_valid = ($urandom_range(0, 2) != 0);
            m_dst   = 4'($urandom_range(0, 7));
            m_data  = 16'($urandom);
            q1_reg  = 4'($urandom_range(0, 7));
            q2_reg  = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 249) == 0) begin
                rst = 1;
                mq.delete();
                tick();
                rst = 0;
            end else begin
                tick();
            end
        end
        idle();
        repeat (8) tick();
        chk("final_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
